// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: startup flush, load-use stall, branch flush, memory freeze.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       ex_pcsrc,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       clearcontrol,
  output logic       idex_flush,
  output logic       exmem_hold,
  output logic       memwb_hold
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [1:0] STARTUP  = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;

  logic [1:0] state_q, state_d;
  logic       cnt_q, cnt_d;
  logic       load_use;
  logic       freeze;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));

  // A pending access freezes the whole pipeline; in MEM_WAIT only mem_ready releases it.
  assign freeze = ((state_q == RUN) && mem_req && !mem_ready) ||
                  ((state_q == MEM_WAIT) && !mem_ready);

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    clearcontrol = 1'b0;
    idex_flush   = 1'b0;
    exmem_hold   = 1'b0;
    memwb_hold   = 1'b0;
    if (state_q == STARTUP) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      clearcontrol = 1'b1;
      idex_flush   = 1'b1;
    end else if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
      memwb_hold = 1'b1;
    end else if (ex_pcsrc) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      clearcontrol = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 1'b0;
    case (state_q)
      STARTUP: begin
        cnt_d = !cnt_q;
        if (cnt_q) state_d = RUN;
      end
      RUN:      if (freeze) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_d = RUN;
      default:  state_d = STARTUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= STARTUP;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        stall_ev, flush_ev;

  assign stall_ev = ((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_write;
  assign flush_ev = (state_q == RUN) && ifid_flush;

  // Counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_ev && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_ev && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising-edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have: id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-004 SHALL have: id_use_rs2  in  1  ID instruction reads rs2 (R/S/B-type).
REQ-005 SHALL have: ex_memread  in  1  instruction in EX is a load; ex_rd  in  5  its destination.
REQ-006 SHALL have: ex_pcsrc  in  1  taken branch, jal or jalr resolved in EX.
REQ-007 SHALL have: mem_req  in  1  MEM stage issues a data access; mem_ready  in  1  data memory completes it this cycle.
REQ-008 SHALL have outputs, all 1 bit: pc_write, ifid_write, ifid_flush, clearcontrol (to Control), idex_flush, exmem_hold, memwb_hold.
REQ-009 SHALL have, when HAZARD_PERF_EN is defined: stall_cnt  out  16, flush_cnt  out  16.

Function
REQ-010 SHALL implement FSM states STARTUP, RUN, MEM_WAIT; state is registered.
REQ-011 STARTUP SHALL last exactly 2 cycles after rst deasserts, counted by a 1-bit counter, then enter RUN.
REQ-012 In STARTUP: pc_write=0, ifid_write=0, ifid_flush=1, clearcontrol=1, idex_flush=1, holds=0.
REQ-013 RUN, no hazard: pc_write=1, ifid_write=1, all flush/clear/hold outputs=0.
REQ-014 Load-use hazard SHALL be ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || (id_use_rs2 && ex_rd==id_rs2)).
REQ-015 Load-use in RUN: same cycle, combinationally, pc_write=0, ifid_write=0, clearcontrol=1; one bubble; state stays RUN.
REQ-016 ex_pcsrc in RUN: same cycle, ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1; load-use stall suppressed.
REQ-017 mem_req && !mem_ready in RUN: next state MEM_WAIT; in that cycle, all stage writes frozen: pc_write=0, ifid_write=0, exmem_hold=1, memwb_hold=1, no flush.
REQ-018 MEM_WAIT SHALL keep the full-freeze outputs of REQ-017 while mem_ready=0.
REQ-019 MEM_WAIT with mem_ready=1: outputs as RUN for that cycle (REQ-013..016 evaluated); next state RUN.
REQ-020 Priority SHALL be STARTUP > memory freeze > ex_pcsrc flush > load-use stall.
REQ-021 ex_pcsrc or load-use during a memory freeze SHALL be deferred, not lost: inputs are held by the frozen pipeline and re-evaluated on release.
REQ-022 mem_req && mem_ready in the same RUN cycle SHALL cause no stall.
REQ-023 Outputs SHALL depend only on state and current inputs; no output register beyond the FSM.

Reset
REQ-024 rst=0 SHALL asynchronously force state STARTUP, clear the startup counter and the perf counters.
REQ-025 While rst=0 outputs SHALL equal the STARTUP values of REQ-012.
REQ-026 Reset asserted mid-MEM_WAIT SHALL abandon the wait; no pending-access state is retained.

Configuration
REQ-027 Macro HAZARD_PERF_EN defined: stall_cnt increments each cycle pc_write=0 in RUN/MEM_WAIT; flush_cnt increments each cycle ifid_flush=1 in RUN.
REQ-028 Both counters SHALL saturate at 16'hFFFF, not wrap.
REQ-029 HAZARD_PERF_EN undefined: counters and stall_cnt/flush_cnt ports SHALL not exist; all other behaviour identical.

Verification
REQ-030 Release rst at cycle 0 -> cycles 0-1 STARTUP outputs (ifid_flush=1, pc_write=0); cycle 2 pc_write=1.
REQ-031 RUN, ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> pc_write=0, clearcontrol=1 for exactly one cycle; ex_rd=0 -> no stall.
REQ-032 ex_pcsrc=1 together with load-use match -> ifid_flush=1, idex_flush=1, pc_write=1, clearcontrol=0.
REQ-033 mem_req=1, mem_ready=0 for 3 cycles, then 1 -> freeze (exmem_hold=1) for 3 cycles, RUN outputs on cycle 4.
REQ-034 rst pulsed low during MEM_WAIT -> immediate STARTUP outputs; 2 cycles STARTUP after release.
REQ-035 HAZARD_PERF_EN defined, 70000 forced stall cycles -> stall_cnt holds 16'hFFFF.
